// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte, loader FSM states
// and the address-width helper.
package uart_prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_SYNC,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } load_state_e;

    // Bits needed to index n entries, never less than 1 so a 1-entry count still has a port.
    function automatic int addr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver on an already-synchronised line; emits one-cycle
// byte_valid on a good stop bit or frame_err on a low stop bit.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a line already back high was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx;
                    err_d   = !rx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
        shift_q <= shift_d;
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program image over UART into a word memory that the CPU fetches from;
// a framed, checksummed transfer switches the CPU from load mode back to run mode.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int INSTR_WIDTH  = 16,
    parameter int DEPTH        = 256,
    localparam int ADDR_W      = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   load_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data,
    output logic                   mode,
    output logic                   load_done,
    output logic                   load_err,
    output logic [ADDR_W:0]        words_loaded
);

    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int BC_W  = addr_width(BYTES);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 4");
    end
    if ((INSTR_WIDTH % 8) != 0 || INSTR_WIDTH == 0) begin : g_bad_iw
        $error("INSTR_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH > 256 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 between 2 and 256");
    end

    logic rx_s1_q, rx_s2_q;
    logic lr_s1_q, lr_s2_q, lr_prev_q;
    logic load_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            lr_prev_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            lr_s1_q   <= load_req;
            lr_s2_q   <= lr_s1_q;
            lr_prev_q <= lr_s2_q;
        end
    end

    assign load_edge = lr_s2_q & ~lr_prev_q;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_s2_q),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    load_state_e            state_q, state_d;
    logic                   mode_q, mode_d;
    logic                   load_done_q, load_done_d;
    logic                   load_err_q, load_err_d;
    logic [ADDR_W:0]        words_loaded_q, words_loaded_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic [ADDR_W:0]        word_cnt_q, word_cnt_d;
    logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]             csum_q, csum_d;
    logic [INSTR_WIDTH-1:0] word_buf_q, word_buf_d;
    logic [ADDR_W:0]        word_nxt;
    logic                   abort;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_waddr;
    logic [INSTR_WIDTH-1:0] mem_wdata;

    assign word_nxt = word_cnt_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d        = state_q;
        load_done_d    = 1'b0;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;
        len_d          = len_q;
        word_cnt_d     = word_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        csum_d         = csum_q;
        word_buf_d     = word_buf_q;
        abort          = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = word_cnt_q[ADDR_W-1:0];
        mem_wdata      = word_buf_q;

        // A reload request outranks everything, including a same-cycle checksum match.
        if (load_edge) begin
            state_d    = ST_WAIT_SYNC;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
        end else begin
            case (state_q)
                ST_WAIT_SYNC: begin
                    if (rx_valid && rx_byte == SYNC_BYTE) begin
                        state_d    = ST_LEN;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        csum_d     = '0;
                    end
                end
                ST_LEN: begin
                    if (rx_ferr) begin
                        abort = 1'b1;
                    end else if (rx_valid) begin
                        if (int'(rx_byte) > DEPTH) begin
                            abort = 1'b1;
                        end else begin
                            len_d   = (ADDR_W + 1)'(rx_byte);
                            csum_d  = rx_byte;
                            state_d = (rx_byte == 8'd0) ? ST_CSUM : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr) begin
                        abort = 1'b1;
                    end else if (rx_valid) begin
                        word_buf_d[int'(byte_cnt_q) * 8 +: 8] = rx_byte;
                        csum_d = csum_q + rx_byte;
                        if (byte_cnt_q == BC_W'(BYTES - 1)) begin
                            mem_we     = 1'b1;
                            mem_wdata  = word_buf_d;
                            byte_cnt_d = '0;
                            word_cnt_d = word_nxt;
                            if (word_nxt == len_q) begin
                                state_d = ST_CSUM;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_ferr) begin
                        abort = 1'b1;
                    end else if (rx_valid) begin
                        if (rx_byte == csum_q) begin
                            state_d        = ST_RUN;
                            load_done_d    = 1'b1;
                            load_err_d     = 1'b0;
                            words_loaded_d = len_q;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (abort) begin
            load_err_d = 1'b1;
            state_d    = ST_WAIT_SYNC;
        end
        mode_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_WAIT_SYNC;
            mode_q         <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
            len_q          <= '0;
            word_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            csum_q         <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
            len_q          <= len_d;
            word_cnt_q     <= word_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            csum_q         <= csum_d;
        end
        word_buf_q <= word_buf_d;
    end

    // Non-blocking read beside the write gives old data on a same-address collision.
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data      = rd_data_q;
    assign mode         = mode_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clk cycles per UART bit and SHALL be at least 4.
REQ-002 Parameter INSTR_WIDTH, default 16, is the program word width and SHALL be a multiple of 8 (BYTES = INSTR_WIDTH/8).
REQ-003 Parameter DEPTH, default 256, is the program word count; power of 2, at most 256; ADDR_W = log2(DEPTH).
REQ-004 clk  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-005 rx  in  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 load_req  in  1  asynchronous level, already debounced; a rising edge requests a reload.
REQ-007 rd_addr  in  ADDR_W  CPU fetch address.
REQ-008 rd_data  out  INSTR_WIDTH  program word at rd_addr.
REQ-009 mode  out  1  1 = load mode (CPU held), 0 = run mode.
REQ-010 load_done  out  1  one-cycle pulse when a frame is accepted.
REQ-011 load_err  out  1  sticky; set on any frame error.
REQ-012 words_loaded  out  ADDR_W+1  word count of the last accepted frame.

Function
REQ-013 rx SHALL pass through a 2-FF synchronizer; load_req SHALL pass through a 2-FF synchronizer followed by a rising-edge detect.
REQ-014 Receiver: a falling edge in idle starts a byte; rx is re-sampled at CLKS_PER_BIT/2; if high, the start is a glitch and the receiver returns to idle.
REQ-015 Data bits are sampled at mid-bit, spaced CLKS_PER_BIT apart; the stop bit is sampled mid-bit; a valid byte emits a one-cycle byte_valid.
REQ-016 A stop bit sampled 0 is a framing error: no byte_valid is emitted and a one-cycle frame_err pulse is raised.
REQ-017 Frame format: sync 0xA5, length L (words), L*BYTES data bytes, checksum byte.
REQ-018 Data bytes are little-endian within a word; words are written to address 0..L-1.
REQ-019 Checksum SHALL equal (L + sum of all data bytes) mod 256.
REQ-020 FSM states: RUN, WAIT_SYNC, LEN, DATA, CSUM.
REQ-021 WAIT_SYNC: 0xA5 -> LEN; any other byte is ignored.
REQ-022 LEN: L > DEPTH -> error; L = 0 -> CSUM; otherwise -> DATA.
REQ-023 DATA: after the last byte of word L-1 -> CSUM.
REQ-024 CSUM: a match -> RUN, load_done pulse, words_loaded = L, load_err cleared; a mismatch -> error.
REQ-025 Error action: set load_err, go to WAIT_SYNC, mode remains 1.
REQ-026 A frame_err in LEN, DATA or CSUM triggers the error action; frame_err in WAIT_SYNC or RUN is ignored.
REQ-027 mode = 0 only in RUN; bytes received in RUN are ignored.
REQ-028 A load_req edge in any state -> WAIT_SYNC, byte and word counters cleared, checksum cleared; load_err is retained.
REQ-029 Memory: one write port (FSM) and one synchronous read port; rd_data is valid 1 cycle after rd_addr.
REQ-030 A read of the address written in the same cycle returns the old data.
REQ-031 Words written before an aborted frame remain in memory; load_err marks them invalid.
REQ-032 load_req and a checksum match in the same cycle: load_req wins, so no load_done pulse and state is WAIT_SYNC.

Reset
REQ-033 Reset SHALL set: state WAIT_SYNC, mode 1, load_done 0, load_err 0, words_loaded 0, receiver idle, all counters 0, synchronizers 1 (rx) / 0 (load_req).
REQ-034 Memory contents are not reset; reset mid-frame discards the partial frame.

Structure
REQ-035 Shared package holds SYNC_BYTE = 0xA5, the FSM state enum, and a width helper for ADDR_W.
REQ-036 The UART receiver is sub-module uart_rx_core (parameter CLKS_PER_BIT; ports clk, reset, rx, byte_data[8], byte_valid, frame_err).

Verification (bench: CLKS_PER_BIT=8, INSTR_WIDTH=16, DEPTH=256)
REQ-037 Send A5 02 34 12 CD AB C0 -> mem[0]=0x1234, mem[1]=0xABCD, load_done pulse, mode=0, words_loaded=2; rd_addr=1 -> rd_data=0xABCD next cycle.
REQ-038 Same frame with checksum C1 -> load_err=1, mode=1, state WAIT_SYNC, no load_done.
REQ-039 Send 11 A5 00 00 -> the 0x11 is ignored; load_done pulses, words_loaded=0, mode=0.
REQ-040 Stop bit 0 on the third data byte -> load_err=1; a following good frame clears load_err and reaches mode=0.
REQ-041 In RUN, raise load_req -> mode=1 within 4 cycles; then send bytes 5A 01 -> no load_done pulse and mode stays 1.
REQ-042 Assert reset mid-DATA, then send a full good frame -> frame is accepted; words_loaded equals the new L.
